nco_config_ctrl: RTL

Sequencing controller for the keypad front end and the NCO phase accumulator. Drives the keypad's 3-bit state code through waveform selection and frequency entry. Converts the captured entry (three BCD digits plus a unit code) into an ACC_W-bit phase-increment tuning word with a sequential shift-subtract divider. Loads the tuning word and waveform code into the NCO with a one-cycle valid strobe.

---
 rtl/nco_config_ctrl.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/nco_config_ctrl.sv
// nco_config_ctrl: keypad sequencer + BCD/unit to NCO tuning-word converter.
// Latency: freq_select sampled high to tw_valid = ACC_W+7 cycles (ACC_W+8 with ROUND_EN).
// Backpressure: none; cfg_req restarts from S_CLR at any time. Optional macro: ROUND_EN.
`timescale 1ns/1ps
module nco_config_ctrl #(
  parameter int          ACC_W    = 32,
  parameter int unsigned F_CLK_HZ = 4000000
) (
  input  logic             clk_4MHz,
  input  logic             rst,
  input  logic             cfg_req,
  input  logic             signal_select,
  input  logic             freq_select,
  input  logic [3:0]       signal_out,
  input  logic [3:0]       value_0,
  input  logic [3:0]       value_1,
  input  logic [3:0]       value_2,
  input  logic [3:0]       value_3,
  output logic [2:0]       state_out,
  output logic [ACC_W-1:0] tuning_word,
  output logic [3:0]       waveform,
  output logic             tw_valid,
  output logic             busy,
  output logic             cfg_err
);

  // Divisor is the clock in mHz; Nyquist limit is half of it.
  localparam logic [39:0] DIVISOR = 40'(F_CLK_HZ) * 40'd1000;
  localparam logic [39:0] NYQ_MHZ = 40'(F_CLK_HZ) * 40'd500;
  localparam logic [5:0]  DIV_LAST = 6'(ACC_W - 1);

  typedef enum logic [3:0] {
    S_CLR, S_SIG, S_FCLR, S_FENT, S_CHK, S_BCD, S_SCALE, S_DIV, S_RND, S_LOAD, S_IDLE
  } state_t;

  state_t           state;
  logic [3:0]       wf_cap;
  logic [3:0]       dig0, dig1, dig2, unit;
  logic [1:0]       step;
  logic [9:0]       n_val;
  logic [39:0]      rem;
  logic [ACC_W-1:0] quot;
  logic [5:0]       cnt;

  logic [3:0]       dig_sel;
  logic [39:0]      f_scaled;
  logic [40:0]      rem_sh;
  logic             rem_ge;
  logic             entry_bad;

  // Datapath helpers: current BCD digit, unit scaling, and one restoring-division step.
  always_comb begin
    dig_sel = dig0;
    case (step)
      2'd1:    dig_sel = dig1;
      2'd2:    dig_sel = dig2;
      default: dig_sel = dig0;
    endcase
    f_scaled = 40'(n_val);
    case (unit)
      4'hB:    f_scaled = 40'(n_val) * 40'd1000;
      4'hC:    f_scaled = 40'(n_val) * 40'd1000000;
      4'hD:    f_scaled = 40'(n_val) * 40'd1000000000;
      default: f_scaled = 40'(n_val);
    endcase
    rem_sh    = {rem, 1'b0};
    rem_ge    = (rem_sh >= {1'b0, DIVISOR});
    entry_bad = (dig0 > 4'd9) || (dig1 > 4'd9) || (dig2 > 4'd9) ||
                (unit < 4'hA) || (unit > 4'hD);
  end

  // Sequencer FSM with registered outputs; cfg_req overrides every state except S_CLR.
  always_ff @(posedge clk_4MHz) begin
    if (rst) begin
      state       <= S_CLR;
      state_out   <= 3'd0;
      tuning_word <= '0;
      waveform    <= 4'd0;
      tw_valid    <= 1'b0;
      busy        <= 1'b0;
      cfg_err     <= 1'b0;
      wf_cap      <= 4'd0;
      dig0        <= 4'd0;
      dig1        <= 4'd0;
      dig2        <= 4'd0;
      unit        <= 4'd0;
      step        <= 2'd0;
      n_val       <= 10'd0;
      rem         <= 40'd0;
      quot        <= '0;
      cnt         <= 6'd0;
    end else begin
      tw_valid <= 1'b0;
      if (cfg_req && state != S_CLR) begin
        state     <= S_CLR;
        state_out <= 3'd0;
        busy      <= 1'b0;
        cfg_err   <= 1'b0;
      end else begin
        case (state)
          S_CLR: begin
            cfg_err   <= 1'b0;
            state     <= S_SIG;
            state_out <= 3'd1;
          end
          S_SIG: begin
            if (signal_select) begin
              wf_cap    <= signal_out;
              state     <= S_FCLR;
              state_out <= 3'd2;
            end
          end
          S_FCLR: begin
            state     <= S_FENT;
            state_out <= 3'd3;
          end
          S_FENT: begin
            if (freq_select) begin
              dig0      <= value_0;
              dig1      <= value_1;
              dig2      <= value_2;
              unit      <= value_3;
              state     <= S_CHK;
              state_out <= 3'd4;
              busy      <= 1'b1;
            end
          end
          S_CHK: begin
            if (entry_bad) begin
              cfg_err   <= 1'b1;
              state     <= S_IDLE;
              state_out <= 3'd5;
              busy      <= 1'b0;
            end else begin
              n_val <= 10'd0;
              step  <= 2'd0;
              state <= S_BCD;
            end
          end
          S_BCD: begin
            // Horner accumulate: max value 999 fits in 10 bits.
            n_val <= n_val * 10'd10 + {6'd0, dig_sel};
            step  <= step + 2'd1;
            if (step == 2'd2) state <= S_SCALE;
          end
          S_SCALE: begin
            if (f_scaled > NYQ_MHZ) begin
              cfg_err   <= 1'b1;
              state     <= S_IDLE;
              state_out <= 3'd5;
              busy      <= 1'b0;
            end else begin
              rem   <= f_scaled;
              quot  <= '0;
              cnt   <= 6'd0;
              state <= S_DIV;
            end
          end
          S_DIV: begin
            // Remainder stays below DIVISOR, so the difference fits back in 40 bits.
            if (rem_ge) begin
              rem  <= 40'(rem_sh - {1'b0, DIVISOR});
              quot <= {quot[ACC_W-2:0], 1'b1};
            end else begin
              rem  <= rem_sh[39:0];
              quot <= {quot[ACC_W-2:0], 1'b0};
            end
            cnt <= cnt + 6'd1;
            if (cnt == DIV_LAST) begin
`ifdef ROUND_EN
              state     <= S_RND;
`else
              state     <= S_LOAD;
              state_out <= 3'd5;
`endif
            end
          end
          S_RND: begin
            // Final remainder doubled against the divisor gives round-half-up.
            if (rem_ge && quot != '1) quot <= quot + 1'b1;
            state     <= S_LOAD;
            state_out <= 3'd5;
          end
          S_LOAD: begin
            tuning_word <= quot;
            waveform    <= wf_cap;
            tw_valid    <= 1'b1;
            state       <= S_IDLE;
            busy        <= 1'b0;
          end
          S_IDLE: begin
            state <= S_IDLE;
          end
          default: begin
            state     <= S_CLR;
            state_out <= 3'd0;
            busy      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
